// File: rtl/bs_player_core.sv
// Per-player Battleship core: fleet and shot registers, opponent shot validation,
// hit counting and the turn state machine.
module bs_player_core #(
  parameter int unsigned CELLS      = 16,
  parameter int unsigned CNT_W      = $clog2(CELLS + 1),
  parameter int unsigned FIRST_TURN = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CELLS-1:0] sw,
  input  logic             load_btn,
  input  logic             fire_btn,
  input  logic [CELLS-1:0] opp_shots,
  input  logic             opp_fire,
  input  logic             opp_alive,
  output logic [CELLS-1:0] my_shots,
  output logic             my_fire,
  output logic [CELLS-1:0] fleet,
  output logic [CNT_W-1:0] hits_taken,
  output logic             alive,
  output logic             shot_err,
  output logic [2:0]       state_code
);

  typedef enum logic [2:0] {
    StLoad   = 3'd0,
    StMyTurn = 3'd1,
    StOpp    = 3'd2,
    StWin    = 3'd3,
    StLose   = 3'd4
  } state_e;

  state_e           state_q;
  logic [CELLS-1:0] opp_prev_q;
  logic             load_q, fire_q, opp_fire_q;

  logic load_edge, fire_edge, opp_edge;
  assign load_edge = load_btn & ~load_q;
  assign fire_edge = fire_btn & ~fire_q;
  assign opp_edge  = opp_fire & ~opp_fire_q;

  // A shot map is valid if it keeps every previous shot and adds exactly one new cell.
  logic [CELLS-1:0] my_new, opp_new, fleet_after;
  logic             my_valid, opp_valid;
  assign my_new      = sw & ~my_shots;
  assign opp_new     = opp_shots & ~opp_prev_q;
  assign my_valid    = ((sw & my_shots) == my_shots) && (my_new != '0) &&
                       ((my_new & (my_new - 1'b1)) == '0);
  assign opp_valid   = ((opp_shots & opp_prev_q) == opp_prev_q) && (opp_new != '0) &&
                       ((opp_new & (opp_new - 1'b1)) == '0);
  assign fleet_after = fleet & ~opp_new;

  assign state_code = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StLoad;
      fleet      <= '0;
      my_shots   <= '0;
      opp_prev_q <= '0;
      hits_taken <= '0;
      my_fire    <= 1'b0;
      shot_err   <= 1'b0;
      alive      <= 1'b1;
      load_q     <= 1'b1;
      fire_q     <= 1'b1;
      opp_fire_q <= 1'b1;
    end else if (clr) begin
      state_q    <= StLoad;
      fleet      <= '0;
      my_shots   <= '0;
      opp_prev_q <= '0;
      hits_taken <= '0;
      my_fire    <= 1'b0;
      shot_err   <= 1'b0;
      alive      <= 1'b1;
      load_q     <= 1'b1;
      fire_q     <= 1'b1;
      opp_fire_q <= 1'b1;
    end else begin
      load_q     <= load_btn;
      fire_q     <= fire_btn;
      opp_fire_q <= opp_fire;
      my_fire    <= 1'b0;
      shot_err   <= 1'b0;
      unique case (state_q)
        StLoad: begin
          if (load_edge) begin
            if (sw != '0) begin
              fleet   <= sw;
              state_q <= (FIRST_TURN == 0) ? StMyTurn : StOpp;
            end else begin
              shot_err <= 1'b1;
            end
          end
        end
        StMyTurn: begin
          if (!opp_alive) begin
            state_q <= StWin;
          end else if (fire_edge) begin
            if (my_valid) begin
              my_shots <= sw;
              my_fire  <= 1'b1;
              state_q  <= StOpp;
            end else begin
              shot_err <= 1'b1;
            end
          end
        end
        StOpp: begin
          if (!opp_alive) begin
            state_q <= StWin;
          end else if (opp_edge) begin
            if (opp_valid) begin
              opp_prev_q <= opp_shots;
              if ((opp_new & fleet) != '0) begin
                fleet <= fleet_after;
                if (hits_taken < CNT_W'(CELLS)) hits_taken <= hits_taken + 1'b1;
                if (fleet_after == '0) begin
                  state_q <= StLose;
                  alive   <= 1'b0;
                end else begin
                  state_q <= StMyTurn;
                end
              end else begin
                state_q <= StMyTurn;
              end
            end else begin
              shot_err <= 1'b1;
            end
          end
        end
        StWin, StLose: ;
        default: state_q <= StLoad;
      endcase
    end
  end

endmodule

// File: tb/tb_bs_player_core.sv
// Directed bench for bs_player_core: load, shot validation, hits, win/lose, clear and reset.
module tb_bs_player_core;

  localparam int unsigned CELLS = 16;
  localparam int unsigned CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst_n, clr, load_btn, fire_btn, opp_fire, opp_alive;
  logic [CELLS-1:0] sw, opp_shots, my_shots, fleet;
  logic             my_fire, alive, shot_err;
  logic [CNT_W-1:0] hits_taken;
  logic [2:0]       state_code;

  int n_checks = 0;
  int n_fail   = 0;

  bs_player_core #(.CELLS(CELLS), .FIRST_TURN(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .sw         (sw),
    .load_btn   (load_btn),
    .fire_btn   (fire_btn),
    .opp_shots  (opp_shots),
    .opp_fire   (opp_fire),
    .opp_alive  (opp_alive),
    .my_shots   (my_shots),
    .my_fire    (my_fire),
    .fleet      (fleet),
    .hits_taken (hits_taken),
    .alive      (alive),
    .shot_err   (shot_err),
    .state_code (state_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_load(input logic [CELLS-1:0] v);
    sw = v; load_btn = 1'b1; tick();
  endtask

  task automatic press_fire(input logic [CELLS-1:0] v);
    sw = v; fire_btn = 1'b1; tick();
  endtask

  task automatic press_opp(input logic [CELLS-1:0] v);
    opp_shots = v; opp_fire = 1'b1; tick();
  endtask

  task automatic release_all();
    load_btn = 1'b0; fire_btn = 1'b0; opp_fire = 1'b0; tick();
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; load_btn = 1'b0; fire_btn = 1'b0; opp_fire = 1'b0;
    opp_alive = 1'b1; sw = '0; opp_shots = '0;
    #12;
    check("rst_state", 32'(state_code), 32'd0);
    check("rst_fleet", 32'(fleet), 32'h0);
    check("rst_alive", 32'(alive), 32'd1);
    check("rst_hits", 32'(hits_taken), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    tick(); tick();

    // 1. empty fleet rejected, then load 0x0007
    press_load(16'h0000);
    check("load0_err", 32'(shot_err), 32'd1);
    check("load0_state", 32'(state_code), 32'd0);
    release_all();
    check("load0_err_clr", 32'(shot_err), 32'd0);
    press_load(16'h0007);
    check("load_fleet", 32'(fleet), 32'h7);
    check("load_state", 32'(state_code), 32'd1);
    check("load_alive", 32'(alive), 32'd1);
    release_all();

    // 2. two-cell shot rejected, then single shot accepted
    press_fire(16'h0011);
    check("fire2_err", 32'(shot_err), 32'd1);
    check("fire2_shots", 32'(my_shots), 32'h0);
    check("fire2_state", 32'(state_code), 32'd1);
    release_all();
    press_fire(16'h0010);
    check("fire_shots", 32'(my_shots), 32'h10);
    check("fire_pulse", 32'(my_fire), 32'd1);
    check("fire_state", 32'(state_code), 32'd2);
    release_all();
    check("fire_pulse_end", 32'(my_fire), 32'd0);

    // 3/4. opponent hits, an invalid opponent map, then sinking
    press_opp(16'h0001);
    check("hit1_fleet", 32'(fleet), 32'h6);
    check("hit1_hits", 32'(hits_taken), 32'd1);
    check("hit1_state", 32'(state_code), 32'd1);
    release_all();
    press_fire(16'h0030);
    check("fire_b_state", 32'(state_code), 32'd2);
    release_all();
    press_opp(16'h0002);
    check("bad_opp_err", 32'(shot_err), 32'd1);
    check("bad_opp_fleet", 32'(fleet), 32'h6);
    check("bad_opp_state", 32'(state_code), 32'd2);
    release_all();
    press_opp(16'h0003);
    check("hit2_fleet", 32'(fleet), 32'h4);
    check("hit2_hits", 32'(hits_taken), 32'd2);
    check("hit2_state", 32'(state_code), 32'd1);
    release_all();
    press_fire(16'h0070);
    release_all();
    press_opp(16'h0007);
    check("sunk_fleet", 32'(fleet), 32'h0);
    check("sunk_hits", 32'(hits_taken), 32'd3);
    check("sunk_state", 32'(state_code), 32'd4);
    check("sunk_alive", 32'(alive), 32'd0);
    release_all();
    press_load(16'h00ff);
    check("lose_terminal", 32'(state_code), 32'd4);
    release_all();

    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_state", 32'(state_code), 32'd0);
    check("clr_alive", 32'(alive), 32'd1);
    check("clr_hits", 32'(hits_taken), 32'd0);
    check("clr_shots", 32'(my_shots), 32'h0);
    tick();

    // 5. opponent dead wins over a simultaneous fire edge
    press_load(16'h0007);
    release_all();
    opp_alive = 1'b0;
    press_fire(16'h0001);
    check("win_state", 32'(state_code), 32'd3);
    check("win_no_fire", 32'(my_fire), 32'd0);
    check("win_shots", 32'(my_shots), 32'h0);
    release_all();
    check("win_no_fire2", 32'(my_fire), 32'd0);
    opp_alive = 1'b1;
    clr = 1'b1; tick(); clr = 1'b0;
    check("win_clr_state", 32'(state_code), 32'd0);
    tick();

    // 6. asynchronous reset mid OPP_TURN, load held through reset
    press_load(16'h0007);
    release_all();
    press_fire(16'h0001);
    check("pre_rst_state", 32'(state_code), 32'd2);
    release_all();
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state_code), 32'd0);
    check("arst_fleet", 32'(fleet), 32'h0);
    check("arst_shots", 32'(my_shots), 32'h0);
    check("arst_alive", 32'(alive), 32'd1);
    sw = 16'h0007; load_btn = 1'b1;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("held_load_state", 32'(state_code), 32'd0);
    check("held_load_fleet", 32'(fleet), 32'h0);
    load_btn = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
